// File: rtl/alu_core_32.sv
// 32-bit A-side execute ALU: operand-2 select, registered operands, adder,
// logic unit and AND-OR result bus driver.
module alu_core_32 (
  input  logic        Phi1,
  input  logic        ResetBAR_s1,
  input  logic        ALatchInputs_s1e,
  input  logic [31:0] ASBus_s1e,
  input  logic [31:0] ATBus_s1e,
  input  logic [31:0] AImm_s1e,
  input  logic        AselT_s1e,
  input  logic        AselTBAR_s1e,
  input  logic        AselImm_s1e,
  input  logic        AselImmBAR_s1e,
  input  logic        AcarryIn_s2e,
  input  logic        AAndOp_s2e,
  input  logic        AOrOp_s2e,
  input  logic        AXorOp_s2e,
  input  logic        ANorOp_s2e,
  input  logic        ASetRes_v2e,
  input  logic        AAddDrv_q2e,
  input  logic        AALUDrv_q2e,
  input  logic        ASetDrv_q2e,
  output logic [31:0] AResultBus_v2e,
  output logic        AcarryOut_v2e,
  output logic        ATorImmMsb_s1e,
  output logic        AAddResMsb_v2e
);

  logic [31:0] tBar;
  logic [31:0] immBar;
  logic [31:0] torImm;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [32:0] addFull;
  logic [31:0] sum;
  logic [31:0] logicBar;
  logic [31:0] logicRes;

  assign tBar   = ~ATBus_s1e;
  assign immBar = ~AImm_s1e;

  // AND-OR select: no select gives 0, several selects OR together
  assign torImm = (ATBus_s1e & {32{AselT_s1e}})
                | (tBar      & {32{AselTBAR_s1e}})
                | (AImm_s1e  & {32{AselImm_s1e}})
                | (immBar    & {32{AselImmBAR_s1e}});

  assign ATorImmMsb_s1e = torImm[31];

  always_ff @(posedge Phi1) begin
    if (!ResetBAR_s1) begin
      src1 <= 32'h0;
      src2 <= 32'h0;
    end else if (ALatchInputs_s1e) begin
      src1 <= ASBus_s1e;
      src2 <= torImm;
    end
  end

  assign addFull        = {1'b0, src1} + {1'b0, src2} + {32'h0, AcarryIn_s2e};
  assign sum            = addFull[31:0];
  assign AcarryOut_v2e  = addFull[32];
  assign AAddResMsb_v2e = sum[31];

  // Logic unit builds the inverted result; the inverter restores polarity
  assign logicBar = ~(((src1 & src2)    & {32{AAndOp_s2e}})
                    | ((src1 | src2)    & {32{AOrOp_s2e}})
                    | ((src1 ^ src2)    & {32{AXorOp_s2e}})
                    | (~(src1 | src2)   & {32{ANorOp_s2e}}));
  assign logicRes = ~logicBar;

  assign AResultBus_v2e = (sum      & {32{AAddDrv_q2e}})
                        | (logicRes & {32{AALUDrv_q2e}})
                        | ({31'h0, ASetRes_v2e} & {32{ASetDrv_q2e}});

endmodule

// File: tb/tb_alu_core_32.sv
// Self-checking bench for alu_core_32: expected results are queued as
// controls are driven and popped when the outputs are sampled.
module tb_alu_core_32;

  logic        Phi1 = 1'b0;
  logic        rstB, en;
  logic [31:0] sBus, tBus, imm;
  logic        selT, selTB, selI, selIB;
  logic        cin, andOp, orOp, xorOp, norOp, setRes;
  logic        addDrv, aluDrv, setDrv;
  logic [31:0] result;
  logic        cout, torMsb, sumMsb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        cout;
    logic        msb;
  } expT;
  expT sbQ[$];

  logic [31:0] mSrc1 = 32'h0;
  logic [31:0] mSrc2 = 32'h0;

  always #5 Phi1 = ~Phi1;

  alu_core_32 dut (
    .Phi1(Phi1), .ResetBAR_s1(rstB), .ALatchInputs_s1e(en),
    .ASBus_s1e(sBus), .ATBus_s1e(tBus), .AImm_s1e(imm),
    .AselT_s1e(selT), .AselTBAR_s1e(selTB), .AselImm_s1e(selI), .AselImmBAR_s1e(selIB),
    .AcarryIn_s2e(cin), .AAndOp_s2e(andOp), .AOrOp_s2e(orOp), .AXorOp_s2e(xorOp),
    .ANorOp_s2e(norOp), .ASetRes_v2e(setRes),
    .AAddDrv_q2e(addDrv), .AALUDrv_q2e(aluDrv), .ASetDrv_q2e(setDrv),
    .AResultBus_v2e(result), .AcarryOut_v2e(cout),
    .ATorImmMsb_s1e(torMsb), .AAddResMsb_v2e(sumMsb)
  );

  task automatic checkVal(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelMux(input logic [31:0] t, input logic [31:0] i,
                                           input logic [3:0] sel);
    logic [31:0] r;
    r = 32'h0;
    if (sel[3]) r = r | t;
    if (sel[2]) r = r | ~t;
    if (sel[1]) r = r | i;
    if (sel[0]) r = r | ~i;
    return r;
  endfunction

  // sel = {T, ~T, Imm, ~Imm}
  task automatic loadOps(input logic [31:0] s, input logic [31:0] t, input logic [31:0] i,
                         input logic [3:0] sel, input logic load);
    @(negedge Phi1);
    sBus = s; tBus = t; imm = i; en = load;
    {selT, selTB, selI, selIB} = sel;
    @(posedge Phi1);
    if (load) begin
      mSrc1 = s;
      mSrc2 = modelMux(t, i, sel);
    end
    #1;
  endtask

  // op = {and, or, xor, nor}, drv = {add, alu, set}
  task automatic driveExp(input string tag, input logic c, input logic [3:0] op,
                          input logic [2:0] drv, input logic sr,
                          input logic [31:0] expRes, input logic expCout, input logic expMsb);
    expT e;
    cin = c;
    {andOp, orOp, xorOp, norOp} = op;
    {addDrv, aluDrv, setDrv} = drv;
    setRes = sr;
    e.tag = tag; e.res = expRes; e.cout = expCout; e.msb = expMsb;
    sbQ.push_back(e);
    #1;
    e = sbQ.pop_front();
    checkVal({e.tag, ".res"},  {1'b0, result}, {1'b0, e.res});
    checkVal({e.tag, ".cout"}, {32'h0, cout},  {32'h0, e.cout});
    checkVal({e.tag, ".msb"},  {32'h0, sumMsb}, {32'h0, e.msb});
  endtask

  // Expected values computed from the bench's operand model
  task automatic driveModel(input string tag, input logic c, input logic [3:0] op,
                            input logic [2:0] drv, input logic sr);
    logic [32:0] a;
    logic [31:0] l, r;
    a = {1'b0, mSrc1} + {1'b0, mSrc2} + {32'h0, c};
    l = 32'h0;
    if (op[3]) l = l | (mSrc1 & mSrc2);
    if (op[2]) l = l | (mSrc1 | mSrc2);
    if (op[1]) l = l | (mSrc1 ^ mSrc2);
    if (op[0]) l = l | ~(mSrc1 | mSrc2);
    r = 32'h0;
    if (drv[2]) r = r | a[31:0];
    if (drv[1]) r = r | l;
    if (drv[0]) r = r | {31'h0, sr};
    driveExp(tag, c, op, drv, sr, r, a[32], a[31]);
  endtask

  initial begin
    rstB = 1'b0; en = 1'b0; sBus = '0; tBus = '0; imm = '0;
    {selT, selTB, selI, selIB} = 4'b0;
    cin = 0; {andOp, orOp, xorOp, norOp} = 4'b0; setRes = 0;
    {addDrv, aluDrv, setDrv} = 3'b0;
    @(posedge Phi1); @(posedge Phi1); #1;
    rstB = 1'b1;

    driveExp("rst_add0", 0, 4'b0000, 3'b100, 0, 32'h0, 0, 0);
    driveExp("rst_add1", 1, 4'b0000, 3'b100, 0, 32'h1, 0, 0);
    driveExp("rst_nor",  0, 4'b0001, 3'b010, 0, 32'hFFFFFFFF, 0, 0);
    driveExp("rst_set",  0, 4'b0000, 3'b001, 1, 32'h1, 0, 0);

    loadOps(32'hFFFFFFFF, 32'h1, 32'h0, 4'b1000, 1);
    driveExp("add_wrap", 0, 4'b0000, 3'b100, 0, 32'h0, 1, 0);

    loadOps(32'd5, 32'd7, 32'h0, 4'b0100, 1);
    driveExp("sub_5_7", 1, 4'b0000, 3'b100, 0, 32'hFFFFFFFE, 0, 1);
    loadOps(32'd7, 32'd5, 32'h0, 4'b0100, 1);
    driveExp("sub_7_5", 1, 4'b0000, 3'b100, 0, 32'h2, 1, 0);

    loadOps(32'hF0F0F0F0, 32'h0, 32'hFF00FF00, 4'b0010, 1);
    driveExp("log_and", 0, 4'b1000, 3'b010, 0, 32'hF000F000, 1, 1);
    driveExp("log_or",  0, 4'b0100, 3'b010, 0, 32'hFFF0FFF0, 1, 1);
    driveExp("log_xor", 0, 4'b0010, 3'b010, 0, 32'h0FF00FF0, 1, 1);
    driveExp("log_nor", 0, 4'b0001, 3'b010, 0, 32'h000F000F, 1, 1);
    driveExp("log_none", 0, 4'b0000, 3'b010, 0, 32'h0, 1, 1);
    driveExp("log_and_xor", 0, 4'b1010, 3'b010, 0, 32'hFFF0FFF0, 1, 1);

    // operand-2 msb is visible before the capturing edge
    @(negedge Phi1);
    sBus = 32'h0; imm = 32'h80000000; en = 1'b1;
    {selT, selTB, selI, selIB} = 4'b0010;
    #1 checkVal("torMsb_imm", {32'h0, torMsb}, 33'h1);
    {selT, selTB, selI, selIB} = 4'b0001;
    #1 checkVal("torMsb_immbar", {32'h0, torMsb}, 33'h0);
    {selT, selTB, selI, selIB} = 4'b0000;
    #1 checkVal("torMsb_none", {32'h0, torMsb}, 33'h0);
    loadOps(32'h0, 32'h0, 32'h80000000, 4'b0001, 1);
    driveExp("set_res1", 0, 4'b0000, 3'b001, 1, 32'h1, 0, 0);
    driveExp("set_res0", 0, 4'b0000, 3'b001, 0, 32'h0, 0, 0);

    loadOps(32'h12345678, 32'h1, 32'h0, 4'b1000, 1);
    driveExp("hold_load", 0, 4'b0000, 3'b100, 0, 32'h12345679, 0, 0);
    for (int k = 0; k < 3; k++)
      loadOps(32'hA5A5A5A5 + k, 32'h5A5A5A5A, 32'h33, 4'b1010, 0);
    driveExp("hold_keep", 0, 4'b0000, 3'b100, 0, 32'h12345679, 0, 0);
    driveExp("hold_cin", 1, 4'b0000, 3'b100, 0, 32'h1234567A, 0, 0);

    @(negedge Phi1);
    rstB = 1'b0; en = 1'b1; sBus = 32'hCAFEF00D; tBus = 32'h11111111;
    {selT, selTB, selI, selIB} = 4'b1000;
    @(posedge Phi1);
    mSrc1 = 32'h0; mSrc2 = 32'h0;
    #1;
    rstB = 1'b1; en = 1'b0;
    driveExp("midrst_c0", 0, 4'b0000, 3'b100, 0, 32'h0, 0, 0);
    driveExp("midrst_c1", 1, 4'b0000, 3'b100, 0, 32'h1, 0, 0);

    loadOps(32'hDEADBEEF, 32'h01234567, 32'h0, 4'b1000, 1);
    driveModel("nodrv", 1, 4'b1111, 3'b000, 1);
    driveModel("multi_add_set", 0, 4'b0000, 3'b101, 1);
    driveModel("multi_sel_or", 0, 4'b0100, 3'b110, 0);

    loadOps(32'h0F0F0000, 32'hFFFF0000, 32'h00FF00FF, 4'b1010, 1);
    driveModel("mux_or_add", 0, 4'b0000, 3'b100, 0);
    loadOps(32'h00000000, 32'hFFFFFFFF, 32'h0, 4'b0000, 1);
    driveExp("mux_none", 1, 4'b0000, 3'b100, 0, 32'h1, 0, 0);

    for (int k = 0; k < 8; k++) begin
      logic [3:0] sel;
      logic [3:0] op;
      logic [2:0] drv;
      sel = 4'b1 << $urandom_range(0, 3);
      op  = 4'b1 << $urandom_range(0, 3);
      drv = 3'b1 << $urandom_range(0, 2);
      loadOps($urandom, $urandom, $urandom, sel, 1);
      driveModel($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), op, drv,
                 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
